// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter family.
package rr_arb_pkg;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-find-first: returns the first set bit of req at or
// after index start, wrapping past N-1 back to 0.
module rr_priority_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  int unsigned cand;

  // Scan farthest-first so the nearest hit to start is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(start) + i;
      if (cand >= N) cand = cand - N;
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding a single-entry registered output stage.
// Optional burst locking on in_last is enabled by defining ARB_LOCK_EN.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  localparam int SEL_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_last,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_WIDTH-1:0]     out_sel,
  input  logic                     out_ready
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [SEL_WIDTH-1:0] start, pick_idx, g;
  logic                 pick_found, found, load, xfer;
  logic [WIDTH-1:0]     req_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req   (in_valid),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_LOCK_EN
  logic                 lock_q, lock_d;
  logic [SEL_WIDTH-1:0] lock_id_q, lock_id_d;

  // A locked channel is reserved for lock_id even while it has nothing to send.
  assign found = lock_q | pick_found;
  assign g     = lock_q ? lock_id_q : pick_idx;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      lock_d    = ~in_last[g];
      lock_id_d = g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign found       = pick_found;
  assign g           = pick_idx;
`endif

  assign load = (state_q == ARB_EMPTY) || (out_ready && state_q == ARB_FULL);

  always_comb begin
    in_ready = '0;
    if (load && found && !rst) in_ready[g] = 1'b1;
  end

  assign xfer = in_valid[g] & in_ready[g];

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      state_d      = ARB_FULL;
      data_d       = req_data[g];
      sel_d        = g;
      last_grant_d = g;
    end else if (state_q == ARB_FULL && out_ready) begin
      state_d = ARB_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_EMPTY;
      data_q       <= '0;
      sel_q        <= '0;
      last_grant_q <= LAST_IDX;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == ARB_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (NUM_REQ=4, WIDTH=8) with hand-computed expectations.
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] dat [4];
  logic [1:0] lock_seq [4];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_sel"},   32'(out_sel),   32'(s));
    chk({tag, "_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'h7E; dat[3] = 8'hFF;
`ifdef ARB_LOCK_EN
    lock_seq[0] = 2'd1; lock_seq[1] = 2'd1; lock_seq[2] = 2'd1; lock_seq[3] = 2'd2;
`else
    lock_seq[0] = 2'd1; lock_seq[1] = 2'd2; lock_seq[2] = 2'd3; lock_seq[3] = 2'd0;
`endif
    in_data   = {dat[3], dat[2], dat[1], dat[0]};
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_last   = 4'h0;
    out_ready = 1'b1;

    // reset held two cycles with every requester asking
    tick();
    tick();
    chk_out("reset", 1'b0, 2'd0, 8'h00);
    chk("reset_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(in_ready), 32'b0001);

    // fairness: ten back-to-back beats, ends holding 3C from requester 1
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), dat[k % 4]);
    end

    // backpressure
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", k), 1'b1, 2'd1, 8'h3C);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("bp_next", 1'b1, 2'd2, 8'h7E);

    // sparse / wrap: bring last_grant to 3, then only 0 and 3 request
    in_valid = 4'b1000;
    tick();
    chk_out("sp_3a", 1'b1, 2'd3, 8'hFF);
    in_valid = 4'b1001;
    #1;
    chk("sp_ready_0", 32'(in_ready), 32'b0001);
    tick();
    chk_out("sp_0a", 1'b1, 2'd0, 8'hA5);
    chk("sp_ready_3", 32'(in_ready), 32'b1000);
    tick();
    chk_out("sp_3b", 1'b1, 2'd3, 8'hFF);
    chk("sp_ready_0b", 32'(in_ready), 32'b0001);
    tick();
    chk_out("sp_0b", 1'b1, 2'd0, 8'hA5);

    // idle drain
    in_valid = 4'b0000;
    tick();
    chk_out("drain_empty", 1'b0, 2'd0, 8'hA5);
    in_valid = 4'b0100;
    #1;
    chk("drain_ready2", 32'(in_ready), 32'b0100);
    tick();
    chk_out("drain_beat", 1'b1, 2'd2, 8'h7E);
    in_valid = 4'b0000;
    tick();
    chk_out("drain_after", 1'b0, 2'd2, 8'h7E);
    in_valid = 4'b0010;
    #1;
    chk("drain_ready1", 32'(in_ready), 32'b0010);
    tick();
    chk_out("drain_next", 1'b1, 2'd1, 8'h3C);

    // burst: last_grant to 0, then requester 1 sends last=0,0,1 while all request
    in_valid = 4'b0001;
    tick();
    chk_out("burst_pre", 1'b1, 2'd0, 8'hA5);
    in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_last = (k == 2) ? 4'b0010 : 4'b0000;
      tick();
      chk_out($sformatf("burst%0d", k), 1'b1, lock_seq[k], dat[lock_seq[k]]);
    end
    in_last = 4'b0000;

    // reset while a beat is held drops it
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk_out("midrst", 1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_grant", 32'(in_ready), 32'b0001);
    tick();
    chk_out("midrst_beat", 1'b1, 2'd0, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit output channel among NUM_REQ valid/ready requesters.
- Drives an internal NUM_REQ-to-1 data select.
- Registers the winning beat into a single-entry output stage and reports which requester supplied it.
- Sits in front of any shared downstream consumer (bus, FIFO, serializer) that previously took a static mux select.

Parameters:
- WIDTH, 8, data width per requester and output.
- NUM_REQ, 4, number of requesters; must be >= 2.
- SEL_WIDTH, $clog2(NUM_REQ), derived localparam; width of grant index.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  NUM_REQ  per-requester valid.
- in_data  input  NUM_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  NUM_REQ  per-requester end-of-burst marker (used only when ARB_LOCK_EN is defined).
- in_ready  output  NUM_REQ  per-requester ready, one-hot or zero.
- out_valid  output  1  output stage holds a beat.
- out_data  output  WIDTH  registered beat.
- out_sel  output  SEL_WIDTH  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so the first search starts at requester 0.
  - State=EMPTY.
  - Reset mid-transfer drops the held beat without signalling.
- States:
  - EMPTY: output register invalid.
  - FULL: output register valid.
- load = (state==EMPTY) || (out_valid && out_ready).
- Grant (combinational):
  - Search in_valid starting at (last_grant+1) mod NUM_REQ, wrapping; first set bit wins (index g).
  - Wrap: when last_grant=NUM_REQ-1, the search starts at 0.
- in_ready[g]=1 only when load=1 and a winner exists; all other in_ready bits are 0.
  - in_ready never depends on in_valid of the same requester beyond the selection itself.
- Transfer on in_valid[g] && in_ready[g]:
  - Next edge: out_data=in_data[g], out_sel=g, out_valid=1, last_grant=g, state=FULL.
- Latency: requester beat appears on out_data 1 cycle after its handshake.
- FULL with out_ready=0:
  - out_valid, out_data and out_sel are held stable.
  - All in_ready=0.
- FULL with out_ready=1:
  - With a winner: new beat loads in the same edge (simultaneous drain and fill); sustained 1 beat/cycle.
  - With no winner: out_valid=0, state=EMPTY; out_data and out_sel keep their last value.
- No requests: last_grant is unchanged.
- Single persistent requester: it wins every cycle; no bubbles.
- All requesters active: grants rotate 0,1,2,3,0,... (for NUM_REQ=4).
- in_valid dropped before its handshake is legal; that requester is simply skipped.
- Design assertion: out_valid && !out_ready implies out_data and out_sel are stable next cycle.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - A grant to g that transfers with in_last[g]=0 sets lock=1 and lock_id=g.
  - While lock=1 the search is bypassed: only requester lock_id can receive in_ready, even if in_valid[lock_id]=0 (the channel idles).
  - lock clears when a beat with in_last[lock_id]=1 transfers; last_grant updates normally.
  - Reset clears lock.
- Not defined:
  - in_last is ignored (port kept, unused).
  - Every beat is arbitrated independently.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum arb_state_t {ARB_EMPTY, ARB_FULL}.
  - Default WIDTH and NUM_REQ constants.
- Sub-module rr_priority_pick:
  - Combinational rotate-and-find-first over NUM_REQ bits given a start index.
  - Outputs found flag and index.
  - Reusable by other arbiters.

Test Plan:
- Reset: hold rst=1 two cycles with all in_valid=1 -> out_valid=0, out_data=8'h00, in_ready=4'b0000; first grant after release goes to requester 0.
- Fairness: all in_valid=1, data A5/3C/7E/FF, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data A5,3C,7E,FF repeating, no bubbles.
- Backpressure: out_valid=1 holding 3C (sel 1), out_ready=0 for 5 cycles -> out_data=3C and out_sel=1 stable, in_ready=0; release -> next grant goes to 2.
- Sparse/wrap: only in_valid[3] and in_valid[0] set, last_grant=3 -> grant 0, then 3, then 0; requesters 1 and 2 never get in_ready.
- Idle drain: single beat from requester 2 then no requests -> out_valid high exactly 1 cycle with out_ready=1, then EMPTY; next request from 1 granted immediately.
- ARB_LOCK_EN: requester 1 sends 3 beats with in_last=0,0,1 while 0/2/3 request -> all three beats come from sel 1 consecutively, then grant moves to 2; without the macro the grants interleave 1,2,3,0.
